// File: rtl/bsk_mgr_common_param_pkg.sv
// Shared BSK manager parameters and the per-cut slice/entry types.
package bsk_mgr_common_param_pkg;

    localparam int BSK_CUT_NB  = 2;
    localparam int CUT_SLICE_W = 64;

    typedef logic [CUT_SLICE_W-1:0] cut_slice_t;

    typedef struct packed {
        logic       last;
        cut_slice_t data;
    } cut_entry_t;

endpackage

// File: rtl/bsk_mgr_cut_gather_fifo.sv
// Single-cut synchronous FIFO; head is always the oldest entry, no bypass.
module bsk_mgr_cut_gather_fifo #(
    parameter int W     = 65,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         a_rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    // Memory is cleared on reset so the head (and thus out_data) reads 0.
    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

endmodule

// File: rtl/bsk_mgr_cut_gather.sv
// Buffers per-cut BSK slices and re-assembles them into full words in order,
// flagging last-of-batch disagreement between cuts and counting batches.
module bsk_mgr_cut_gather
    import bsk_mgr_common_param_pkg::*;
#(
    parameter int CUT_W       = CUT_SLICE_W,
    parameter int FIFO_DEPTH  = 4,
    parameter int BATCH_CNT_W = 16
) (
    input  logic                        clk,
    input  logic                        a_rst,
    input  logic [BSK_CUT_NB*CUT_W-1:0] in_cut_data,
    input  logic [BSK_CUT_NB-1:0]       in_cut_last,
    input  logic [BSK_CUT_NB-1:0]       in_cut_vld,
    output logic [BSK_CUT_NB-1:0]       in_cut_rdy,
    output logic [BSK_CUT_NB*CUT_W-1:0] out_data,
    output logic                        out_last,
    output logic                        out_vld,
    input  logic                        out_rdy,
    output logic                        err_last_mismatch,
    output logic [BATCH_CNT_W-1:0]      batch_cnt
);

    // Handshake: a transfer happens on a cycle where both vld and rdy are high;
    // in_cut_rdy depends only on stored FIFO state, never on out_rdy.
    logic                  rdy_en;
    logic [BSK_CUT_NB-1:0] push;
    logic [BSK_CUT_NB-1:0] full;
    logic [BSK_CUT_NB-1:0] empty;
    logic [BSK_CUT_NB-1:0] head_last;
    logic [CUT_W:0]        head [BSK_CUT_NB];
    logic                  pop;
    logic                  mismatch;

    // Holds rdy low during reset and releases it on the first clock after.
    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            rdy_en <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
        end
    end

    assign in_cut_rdy = {BSK_CUT_NB{rdy_en}} & ~full;
    assign out_vld    = &(~empty);
    assign pop        = out_vld & out_rdy;

    for (genvar c = 0; c < BSK_CUT_NB; c++) begin : g_cut
        assign push[c] = in_cut_vld[c] & in_cut_rdy[c];

        bsk_mgr_cut_gather_fifo #(
            .W     (CUT_W + 1),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk       (clk),
            .a_rst     (a_rst),
            .push      (push[c]),
            .push_data ({in_cut_last[c], in_cut_data[c*CUT_W +: CUT_W]}),
            .pop       (pop),
            .head      (head[c]),
            .full      (full[c]),
            .empty     (empty[c])
        );

        assign out_data[c*CUT_W +: CUT_W] = head[c][CUT_W-1:0];
        assign head_last[c]               = head[c][CUT_W];
    end

    assign out_last = head_last[0];
    assign mismatch = out_vld & (|(head_last ^ {BSK_CUT_NB{head_last[0]}}));

    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            err_last_mismatch <= 1'b0;
            batch_cnt         <= '0;
        end else begin
            if (mismatch) begin
                err_last_mismatch <= 1'b1;
            end
            if (pop && out_last) begin
                batch_cnt <= batch_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bsk_mgr_cut_gather.sv
// Directed bench for bsk_mgr_cut_gather with an in-order output scoreboard.
module tb_bsk_mgr_cut_gather;
    import bsk_mgr_common_param_pkg::*;

    localparam int N  = BSK_CUT_NB;
    localparam int CW = CUT_SLICE_W;
    localparam int BW = 2;

    logic              clk;
    logic              a_rst;
    logic [N*CW-1:0]   in_cut_data;
    logic [N-1:0]      in_cut_last;
    logic [N-1:0]      in_cut_vld;
    logic [N-1:0]      in_cut_rdy;
    logic [N*CW-1:0]   out_data;
    logic              out_last;
    logic              out_vld;
    logic              out_rdy;
    logic              err_last_mismatch;
    logic [BW-1:0]     batch_cnt;

    logic [N*CW:0]     exp_q [$];
    logic [N*CW:0]     mon_exp;
    int                vectors = 0;
    int                miscompares = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    bsk_mgr_cut_gather #(
        .CUT_W       (CW),
        .FIFO_DEPTH  (4),
        .BATCH_CNT_W (BW)
    ) dut (
        .clk               (clk),
        .a_rst             (a_rst),
        .in_cut_data       (in_cut_data),
        .in_cut_last       (in_cut_last),
        .in_cut_vld        (in_cut_vld),
        .in_cut_rdy        (in_cut_rdy),
        .out_data          (out_data),
        .out_last          (out_last),
        .out_vld           (out_vld),
        .out_rdy           (out_rdy),
        .err_last_mismatch (err_last_mismatch),
        .batch_cnt         (batch_cnt)
    );

    task automatic check(input string name, input logic [N*CW:0] act, input logic [N*CW:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [N*CW:0] word(input logic [CW-1:0] d0, input logic [CW-1:0] d1, input logic l);
        return {l, d1, d0};
    endfunction

    // Presents one beat from posedge+1 so it is sampled at the next edge.
    task automatic drive(input logic [N-1:0] vld, input logic [CW-1:0] d0, input logic [CW-1:0] d1,
                         input logic l0, input logic l1);
        in_cut_vld  = vld;
        in_cut_data = {d1, d0};
        in_cut_last = {l1, l0};
        @(posedge clk);
        #1;
        in_cut_vld  = '0;
        in_cut_last = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted output word is checked against the queue head.
    always @(negedge clk) begin
        if (!a_rst && out_vld && out_rdy) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_word: got %0h expected none", {out_last, out_data});
            end else begin
                mon_exp = exp_q.pop_front();
                check("out_word", {out_last, out_data}, mon_exp);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int wait_cyc;
        logic [BW-1:0] exp_b;

        a_rst       = 1'b1;
        in_cut_vld  = '0;
        in_cut_data = '0;
        in_cut_last = '0;
        out_rdy     = 1'b0;
        #2;
        check("rst_rdy", in_cut_rdy, 0);
        check("rst_vld", out_vld, 0);
        check("rst_data", out_data, 0);
        check("rst_last", out_last, 0);
        check("rst_err", err_last_mismatch, 0);
        check("rst_batch", batch_cnt, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        a_rst = 1'b0;
        check("rdy_still_low", in_cut_rdy, 0);
        idle(1);
        check("rdy_after_rst", in_cut_rdy, 2'b11);

        // Aligned stream
        out_rdy = 1'b1;
        check("aligned_idle_vld", out_vld, 0);
        exp_q.push_back(word(64'h11, 64'h21, 1'b0));
        drive(2'b11, 64'h11, 64'h21, 1'b0, 1'b0);
        check("aligned_lat1_w0", out_vld, 1);
        exp_q.push_back(word(64'h12, 64'h22, 1'b0));
        drive(2'b11, 64'h12, 64'h22, 1'b0, 1'b0);
        check("aligned_lat1_w1", out_vld, 1);
        idle(1);
        check("aligned_drained", out_vld, 0);

        // Skewed cuts
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(word(64'(32'h30 + k), 64'(32'h40 + k), 1'b0));
        end
        for (int t = 0; t < 8; t++) begin
            drive({(t >= 5), (t <= 2)}, 64'(32'h30 + t), 64'(32'h40 + t - 5), 1'b0, 1'b0);
            check("skew_vld", out_vld, (t >= 5));
        end
        idle(1);
        check("skew_drained", out_vld, 0);

        // Backpressure
        out_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("bp_rdy0_before", in_cut_rdy[0], (i < 4));
            drive(2'b01, 64'(32'h50 + i), 64'h0, 1'b0, 1'b0);
        end
        check("bp_rdy0_full", in_cut_rdy[0], 0);
        check("bp_rdy1_free", in_cut_rdy[1], 1);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(word(64'(32'h50 + i), 64'(32'h60 + i), 1'b0));
            drive(2'b10, 64'h0, 64'(32'h60 + i), 1'b0, 1'b0);
        end
        check("bp_rdy1_full", in_cut_rdy[1], 0);
        check("bp_vld", out_vld, 1);
        out_rdy = 1'b1;
        check("bp_no_comb_path", in_cut_rdy[0], 0);
        idle(1);
        check("bp_rdy0_back", in_cut_rdy[0], 1);
        idle(4);
        check("bp_drained", out_vld, 0);

        // Last mismatch
        check("mm_err_before", err_last_mismatch, 0);
        exp_q.push_back(word(64'h71, 64'h81, 1'b1));
        drive(2'b11, 64'h71, 64'h81, 1'b1, 1'b0);
        check("mm_err_not_yet", err_last_mismatch, 0);
        check("mm_out_last", out_last, 1);
        idle(1);
        check("mm_err_set", err_last_mismatch, 1);
        check("mm_batch", batch_cnt, 1);
        idle(3);
        check("mm_err_sticky", err_last_mismatch, 1);

        // Reset mid-stream: buffered words must never appear
        out_rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(2'b11, 64'(32'h90 + k), 64'(32'hA0 + k), 1'b0, 1'b0);
        end
        check("mrst_buffered", out_vld, 1);
        a_rst = 1'b1;
        #1;
        check("mrst_vld_now", out_vld, 0);
        check("mrst_rdy_now", in_cut_rdy, 0);
        check("mrst_data_now", out_data, 0);
        out_rdy = 1'b1;
        idle(2);
        a_rst = 1'b0;
        check("mrst_err_clr", err_last_mismatch, 0);
        check("mrst_batch_clr", batch_cnt, 0);
        idle(1);
        check("mrst_rdy_back", in_cut_rdy, 2'b11);
        check("mrst_empty", out_vld, 0);
        idle(3);
        check("mrst_no_stale", out_vld, 0);

        // Batch counter wrap with a 2-bit counter: 1,2,3,0,1
        exp_b = '0;
        for (int b = 0; b < 5; b++) begin
            exp_q.push_back(word(64'(32'hB0 + b), 64'(32'hC0 + b), 1'b0));
            drive(2'b11, 64'(32'hB0 + b), 64'(32'hC0 + b), 1'b0, 1'b0);
            exp_q.push_back(word(64'(32'hD0 + b), 64'(32'hE0 + b), 1'b1));
            drive(2'b11, 64'(32'hD0 + b), 64'(32'hE0 + b), 1'b1, 1'b1);
            idle(1);
            exp_b = exp_b + 1'b1;
            check("wrap_batch", batch_cnt, exp_b);
        end
        check("wrap_no_err", err_last_mismatch, 0);

        wait_cyc = 0;
        while (exp_q.size() != 0 && wait_cyc < 20) begin
            idle(1);
            wait_cyc++;
        end
        check("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
